// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and LSU ports, with an in-order owner FIFO routing responses back.
// Optional MEM_BUS_ARB_RR_EN selects round-robin arbitration; the default is fixed priority with data over fetch.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 instr_req,
  input  logic [ADDR_WIDTH-1:0]                instr_addr,
  output logic                                 instr_gnt,
  output logic [DATA_WIDTH-1:0]                instr_rdata,
  output logic                                 instr_valid,
  output logic                                 instr_err,
  input  logic                                 data_req,
  input  logic                                 data_wr,
  input  logic [ADDR_WIDTH-1:0]                data_addr,
  input  logic [DATA_WIDTH-1:0]                data_wdata,
  input  logic [DATA_WIDTH/8-1:0]              data_be,
  output logic                                 data_gnt,
  output logic [DATA_WIDTH-1:0]                data_rdata,
  output logic                                 data_valid,
  output logic                                 data_err,
  output logic                                 bus_req,
  output logic                                 bus_wr,
  output logic [ADDR_WIDTH-1:0]                bus_addr,
  output logic [DATA_WIDTH-1:0]                bus_wdata,
  output logic [DATA_WIDTH/8-1:0]              bus_be,
  input  logic                                 bus_gnt,
  input  logic [DATA_WIDTH-1:0]                bus_rdata,
  input  logic                                 bus_valid,
  input  logic                                 bus_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 spurious_rsp
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

  owner_e                 fifo_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic                   lock;
  owner_e                 lock_owner;
  owner_e                 winner;
  owner_e                 sel;
  owner_e                 head;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   owner_req;

  assign full  = (outstanding_cnt == CNT_WIDTH'(MAX_OUTSTANDING));
  assign empty = (outstanding_cnt == '0);

`ifdef MEM_BUS_ARB_RR_EN
  owner_e last_owner;

  always_comb begin
    winner = OWN_INSTR;
    if (instr_req && data_req) winner = (last_owner == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    else if (data_req)         winner = OWN_DATA;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  last_owner <= OWN_INSTR;
    else if (push) last_owner <= sel;
  end
`else
  assign winner = data_req ? OWN_DATA : OWN_INSTR;
`endif

  assign sel     = lock ? lock_owner : winner;
  assign bus_req = (instr_req | data_req) & ~full;
  assign push    = bus_req & bus_gnt;
  assign pop     = bus_valid & ~empty;

  always_comb begin
    bus_wr    = 1'b0;
    bus_addr  = instr_addr;
    bus_wdata = '0;
    bus_be    = '1;
    if (sel == OWN_DATA) begin
      bus_wr    = data_wr;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
      bus_be    = data_be;
    end
  end

  assign instr_gnt = push & (sel == OWN_INSTR);
  assign data_gnt  = push & (sel == OWN_DATA);

  assign head        = fifo_q[rd_ptr];
  assign instr_valid = pop & (head == OWN_INSTR);
  assign data_valid  = pop & (head == OWN_DATA);
  assign instr_rdata = bus_rdata;
  assign data_rdata  = bus_rdata;
  assign instr_err   = bus_err & instr_valid;
  assign data_err    = bus_err & data_valid;

  // A stalled request stays pinned to its owner until handshake, or until that owner withdraws.
  assign owner_req = (lock_owner == OWN_DATA) ? data_req : instr_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock       <= 1'b0;
      lock_owner <= OWN_INSTR;
    end else if (push) begin
      lock <= 1'b0;
    end else if (lock && !owner_req) begin
      lock <= 1'b0;
    end else if (bus_req) begin
      lock       <= 1'b1;
      lock_owner <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      outstanding_cnt <= '0;
      spurious_rsp    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_WIDTH'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_WIDTH'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
      if (bus_valid && empty) spurious_rsp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_mem_bus_arbiter;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_req, data_req, data_wr, bus_gnt, bus_valid, bus_err;
  logic [31:0] instr_addr, data_addr, data_wdata, bus_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_valid, instr_err, data_gnt, data_valid, data_err;
  logic        bus_req, bus_wr, spurious_rsp;
  logic [31:0] instr_rdata, data_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [1:0]  outstanding_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rdata(instr_rdata), .instr_valid(instr_valid), .instr_err(instr_err),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_gnt(data_gnt), .data_rdata(data_rdata), .data_valid(data_valid),
    .data_err(data_err), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rdata(bus_rdata),
    .bus_valid(bus_valid), .bus_err(bus_err), .outstanding_cnt(outstanding_cnt),
    .spurious_rsp(spurious_rsp)
  );

  task automatic idle;
    instr_req = 0; instr_addr = 0; data_req = 0; data_wr = 0; data_addr = 0;
    data_wdata = 0; data_be = 0; bus_gnt = 0; bus_rdata = 0; bus_valid = 0; bus_err = 0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset_n = 0; idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset;
    reset_n = 0; idle();
    tick(); #2;
    checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", outstanding_cnt); end
    checks++; if (spurious_rsp !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b expected 0", spurious_rsp); end
    checks++; if ({bus_req, instr_gnt, data_gnt, instr_valid, data_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {bus_req, instr_gnt, data_gnt, instr_valid, data_valid}); end
  endtask

  task automatic test_single_fetch;
    do_reset();
    instr_req = 1; instr_addr = 32'h80; bus_gnt = 1; #2;
    checks++; if (bus_addr !== 32'h80) begin errors++; $display("FAIL fetch_addr: got %h expected 00000080", bus_addr); end
    checks++; if ({instr_gnt, data_gnt, bus_wr} !== 3'b100) begin errors++; $display("FAIL fetch_gnt: got %b expected 100", {instr_gnt, data_gnt, bus_wr}); end
    checks++; if (bus_be !== 4'hF || bus_wdata !== 32'h0) begin errors++; $display("FAIL fetch_be_wdata: got %h/%h expected f/0", bus_be, bus_wdata); end
    tick(); instr_req = 0; bus_gnt = 0; #2;
    checks++; if (outstanding_cnt !== 2'd1) begin errors++; $display("FAIL fetch_cnt1: got %0d expected 1", outstanding_cnt); end
    tick(); bus_valid = 1; bus_rdata = 32'h13; #2;
    checks++; if ({instr_valid, data_valid, instr_err} !== 3'b100) begin errors++; $display("FAIL fetch_valid: got %b expected 100", {instr_valid, data_valid, instr_err}); end
    checks++; if (instr_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %h expected 00000013", instr_rdata); end
    tick(); bus_valid = 0; #2;
    checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL fetch_cnt0: got %0d expected 0", outstanding_cnt); end
  endtask

  task automatic test_contention;
    do_reset();
    instr_req = 1; instr_addr = 32'h100; data_req = 1; data_wr = 1; data_addr = 32'h2000;
    data_wdata = 32'hDEADBEEF; data_be = 4'hF; bus_gnt = 1; #2;
    checks++; if ({data_gnt, instr_gnt, bus_wr} !== 3'b101) begin errors++; $display("FAIL cont_t0_gnt: got %b expected 101", {data_gnt, instr_gnt, bus_wr}); end
    checks++; if (bus_addr !== 32'h2000 || bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cont_t0_bus: got %h/%h expected 2000/deadbeef", bus_addr, bus_wdata); end
    tick(); data_req = 0; #2;
    checks++; if ({data_gnt, instr_gnt, bus_wr} !== 3'b010 || bus_addr !== 32'h100) begin
      errors++; $display("FAIL cont_t1: got %b addr %h expected 010 addr 100", {data_gnt, instr_gnt, bus_wr}, bus_addr); end
    tick(); instr_req = 0; bus_gnt = 0; bus_valid = 1; bus_rdata = 32'hAAAA; bus_err = 1; #2;
    checks++; if ({data_valid, data_err, instr_valid, outstanding_cnt} !== 5'b11010) begin
      errors++; $display("FAIL cont_rsp1: got %b expected 11010", {data_valid, data_err, instr_valid, outstanding_cnt}); end
    tick(); bus_rdata = 32'hBBBB; bus_err = 0; #2;
    checks++; if ({instr_valid, data_valid} !== 2'b10 || instr_rdata !== 32'hBBBB) begin
      errors++; $display("FAIL cont_rsp2: got %b %h expected 10 0000bbbb", {instr_valid, data_valid}, instr_rdata); end
    tick(); bus_valid = 0; #2;
    checks++; if (outstanding_cnt !== 2'd0) begin errors++; $display("FAIL cont_cnt: got %0d expected 0", outstanding_cnt); end
  endtask

  task automatic test_lock;
    do_reset();
    data_req = 1; data_wr = 1; data_addr = 32'h2000; data_wdata = 32'h1; data_be = 4'h3;
    for (int t = 0; t < 4; t++) begin
      if (t == 1) begin instr_req = 1; instr_addr = 32'h100; end
      bus_gnt = (t == 3); #2;
      checks++; if (bus_addr !== 32'h2000) begin errors++; $display("FAIL lock_addr_t%0d: got %h expected 00002000", t, bus_addr); end
      checks++; if ({data_gnt, instr_gnt} !== {(t == 3), 1'b0}) begin errors++; $display("FAIL lock_gnt_t%0d: got %b expected %b0", t, {data_gnt, instr_gnt}, (t == 3)); end
      tick();
    end
    data_req = 0; bus_gnt = 0; bus_valid = 1; #2;
    checks++; if ({data_valid, bus_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL lock_t4: got %b %h expected 1 100", data_valid, bus_addr); end
    tick(); bus_valid = 0; data_req = 1; data_wr = 0; data_addr = 32'h3000; #2;
    checks++; if (bus_addr !== 32'h100 || {instr_gnt, data_gnt} !== 2'b00) begin
      errors++; $display("FAIL lock_instr_held: got %h %b expected 100 00", bus_addr, {instr_gnt, data_gnt}); end
    tick(); bus_gnt = 1; #2;
    checks++; if (instr_gnt !== 1'b1 || bus_addr !== 32'h100) begin errors++; $display("FAIL lock_instr_gnt: got %b %h expected 1 100", instr_gnt, bus_addr); end
    tick(); instr_req = 0; #2;
    checks++; if ({data_gnt, bus_wr, bus_addr} !== {2'b10, 32'h3000}) begin errors++; $display("FAIL lock_data_after: got %b %b %h expected 1 0 3000", data_gnt, bus_wr, bus_addr); end
  endtask

  task automatic test_full;
    do_reset();
    instr_req = 1; instr_addr = 32'h40; bus_gnt = 1;
    for (int t = 0; t < 2; t++) begin
      #2;
      checks++; if (instr_gnt !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b expected 1", t, instr_gnt); end
      tick();
    end
    data_req = 1; data_addr = 32'h500; #2;
    checks++; if ({outstanding_cnt, bus_req, instr_gnt, data_gnt} !== 5'b10000) begin
      errors++; $display("FAIL full_block: got %b expected 10000", {outstanding_cnt, bus_req, instr_gnt, data_gnt}); end
    tick(); bus_valid = 1; #2;
    checks++; if ({bus_req, instr_valid} !== 2'b01) begin errors++; $display("FAIL full_pop_same: got %b expected 01", {bus_req, instr_valid}); end
    tick(); bus_valid = 0; #2;
    checks++; if ({outstanding_cnt, bus_req, data_gnt} !== 4'b0111) begin errors++; $display("FAIL full_release: got %b expected 0111", {outstanding_cnt, bus_req, data_gnt}); end
  endtask

  task automatic test_spurious;
    do_reset();
    bus_valid = 1; bus_rdata = 32'h55; #2;
    checks++; if ({instr_valid, data_valid, spurious_rsp} !== 3'b000) begin errors++; $display("FAIL spur_valids: got %b expected 000", {instr_valid, data_valid, spurious_rsp}); end
    tick(); bus_valid = 0;
    repeat (3) tick();
    #2;
    checks++; if ({spurious_rsp, outstanding_cnt} !== 3'b100) begin errors++; $display("FAIL spur_sticky: got %b expected 100", {spurious_rsp, outstanding_cnt}); end
    reset_n = 0; tick(); #2;
    checks++; if ({spurious_rsp, outstanding_cnt} !== 3'b000) begin errors++; $display("FAIL spur_reset: got %b expected 000", {spurious_rsp, outstanding_cnt}); end
    reset_n = 1; tick();
  endtask

  task automatic test_arbitration_stream;
    do_reset();
    instr_req = 1; instr_addr = 32'h10; data_req = 1; data_addr = 32'h20; bus_gnt = 1;
    for (int t = 0; t < 6; t++) begin
      bus_valid = (t > 0); #2;
`ifdef MEM_BUS_ARB_RR_EN
      checks++; if ({data_gnt, instr_gnt} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_order_t%0d: got %b expected %b", t, {data_gnt, instr_gnt}, (t % 2 == 0) ? 2'b10 : 2'b01); end
`else
      checks++; if ({data_gnt, instr_gnt} !== 2'b10) begin errors++; $display("FAIL fixed_stream_t%0d: got %b expected 10", t, {data_gnt, instr_gnt}); end
`endif
      tick();
    end
    idle();
  endtask

  task automatic test_random;
    int q[$];
    bit stalled, ipend, dpend, full, e_req, e_iv, e_dv;
    int stall_own, last, sel;
    logic [31:0] ia, da, dwd, e_addr, e_wdata;
    logic [3:0] dbe, e_be;
    logic dw, e_wr;
    do_reset();
    stalled = 0; ipend = 0; dpend = 0; last = 0;
    ia = 0; da = 0; dwd = 0; dbe = 0; dw = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!ipend && $urandom_range(2) == 0) begin ipend = 1; ia = $urandom; end
      if (!dpend && $urandom_range(2) == 0) begin
        dpend = 1; da = $urandom; dwd = $urandom; dbe = 4'($urandom); dw = 1'($urandom);
      end
      instr_req = ipend; instr_addr = ia;
      data_req = dpend; data_addr = da; data_wdata = dwd; data_be = dbe; data_wr = dw;
      bus_gnt = ($urandom_range(9) < 6);
      bus_valid = (q.size() > 0) && ($urandom_range(1) == 1);
      bus_rdata = $urandom; bus_err = 1'($urandom);
      full = (q.size() == MAXO);
      e_req = (ipend || dpend) && !full;
      if (stalled) sel = stall_own;
`ifdef MEM_BUS_ARB_RR_EN
      else if (ipend && dpend) sel = (last == 0) ? 1 : 0;
`else
      else if (ipend && dpend) sel = 1;
`endif
      else sel = dpend ? 1 : 0;
      e_addr = sel ? da : ia; e_wr = sel ? dw : 1'b0; e_wdata = sel ? dwd : 32'h0; e_be = sel ? dbe : 4'hF;
      e_iv = bus_valid && q.size() > 0 && q[0] == 0;
      e_dv = bus_valid && q.size() > 0 && q[0] == 1;
      #2;
      checks++; if ({bus_req, bus_wr, bus_addr, bus_wdata, bus_be} !== {e_req, e_wr, e_addr, e_wdata, e_be}) begin
        errors++; $display("FAIL rnd_bus c%0d: got %b %b %h %h %h expected %b %b %h %h %h", cyc,
          bus_req, bus_wr, bus_addr, bus_wdata, bus_be, e_req, e_wr, e_addr, e_wdata, e_be); end
      checks++; if ({instr_gnt, data_gnt} !== {e_req && bus_gnt && sel == 0, e_req && bus_gnt && sel == 1}) begin
        errors++; $display("FAIL rnd_gnt c%0d: got %b expected sel %0d req %b gnt %b", cyc, {instr_gnt, data_gnt}, sel, e_req, bus_gnt); end
      checks++; if ({instr_valid, data_valid, instr_err, data_err} !== {e_iv, e_dv, e_iv && bus_err, e_dv && bus_err}) begin
        errors++; $display("FAIL rnd_rsp c%0d: got %b expected %b", cyc, {instr_valid, data_valid, instr_err, data_err},
          {e_iv, e_dv, e_iv && bus_err, e_dv && bus_err}); end
      checks++; if (instr_rdata !== bus_rdata || data_rdata !== bus_rdata) begin
        errors++; $display("FAIL rnd_rdata c%0d: got %h/%h expected %h", cyc, instr_rdata, data_rdata, bus_rdata); end
      checks++; if (outstanding_cnt !== 2'(q.size()) || spurious_rsp !== 1'b0) begin
        errors++; $display("FAIL rnd_cnt c%0d: got %0d/%b expected %0d/0", cyc, outstanding_cnt, spurious_rsp, q.size()); end
      if (bus_valid && q.size() > 0) void'(q.pop_front());
      if (e_req && bus_gnt) begin
        q.push_back(sel); last = sel; stalled = 0;
        if (sel == 1) dpend = 0; else ipend = 0;
      end else if (e_req) begin
        stalled = 1; stall_own = sel;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_spurious();
    test_arbitration_stream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
